// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : MEM pipeline stage. Runs the data-bus handshake, formats load and
//            store lanes, aborts hung bus transactions and registers the
//            MEM/WB result. Optional macro MEM_MISALIGN_CHECK_EN traps
//            misaligned halfword/word accesses instead of issuing them.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rs2_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_pc_plus_4,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic        i_reg_write,
    input  logic        i_mem_to_reg,
    input  logic        i_jump,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd_addr,
    output logic        o_wb_reg_write,
    output logic        o_bus_err,
    output logic        o_misalign
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        bus_err_q, bus_err_d;

    logic        w_memop;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_timeout;
    logic        w_misalign;
    logic        w_req;
    logic        w_done;
    logic        w_retire;
    logic [1:0]  w_ofs;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_store_data;
    logic [3:0]  w_store_mask;
    logic        w_unused;

    // Write-back source is chosen by i_jump/i_mem_read alone.
    assign w_unused   = i_mem_to_reg;

    assign w_memop    = i_valid & (i_mem_read | i_mem_write);
    assign w_is_load  = i_mem_read;
    assign w_is_store = ~i_mem_read & i_mem_write;
    assign w_ofs      = i_alu_result[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    logic w_misaligned;
    logic misalign_q, misalign_d;

    always_comb begin
        w_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b01:   w_misaligned = w_ofs[0];
            2'b10:   w_misaligned = (w_ofs != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Trapped in IDLE so the bus never sees the access.
    assign w_misalign = w_memop & w_misaligned & (state_q == S_IDLE);
    assign misalign_d = w_retire & w_misalign;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign o_misalign = misalign_q;
`else
    assign w_misalign = 1'b0;
    assign o_misalign = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_done    = 1'b0;
        w_timeout = (state_q != S_IDLE) && (cnt_q == C_TIMEOUT);
        w_req     = (state_q == S_REQ) && !w_timeout;
        case (state_q)
            S_IDLE: begin
                if (w_misalign) begin
                    w_done = 1'b1;
                end else if (w_memop) begin
                    state_d = S_REQ;
                    cnt_d   = 8'd0;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                // Abort wins over a same-cycle handshake: the request is already dropped.
                if (w_timeout) begin
                    state_d = S_IDLE;
                    w_done  = 1'b1;
                end else if (i_dmem_ready) begin
                    if (w_is_load) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                        w_done  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (w_timeout || i_dmem_rvalid) begin
                    state_d = S_IDLE;
                    w_done  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign w_retire = i_valid & (~w_memop | w_done);

    always_comb begin
        w_byte = 8'h00;
        case (w_ofs)
            2'd0:    w_byte = i_dmem_rdata[7:0];
            2'd1:    w_byte = i_dmem_rdata[15:8];
            2'd2:    w_byte = i_dmem_rdata[23:16];
            default: w_byte = i_dmem_rdata[31:24];
        endcase
        w_half = w_ofs[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (i_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = i_dmem_rdata;
        endcase
    end

    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                w_store_mask = 4'b0001 << w_ofs;
                w_store_data = {4{i_rs2_rdata[7:0]}};
            end
            2'b01: begin
                w_store_mask = 4'b0011 << {w_ofs[1], 1'b0};
                w_store_data = {2{i_rs2_rdata[15:0]}};
            end
            default: begin
                w_store_mask = 4'b1111;
                w_store_data = i_rs2_rdata;
            end
        endcase
    end

    always_comb begin
        wb_valid_d     = w_retire;
        wb_reg_write_d = w_retire & i_reg_write & ~w_timeout & ~w_misalign;
        bus_err_d      = w_retire & w_timeout;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        if (w_retire) begin
            wb_rd_d = i_rd_addr;
            if (i_jump) begin
                wb_data_d = i_pc_plus_4;
            end else if (i_mem_read) begin
                wb_data_d = w_load_data;
            end else begin
                wb_data_d = i_alu_result;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= 32'h0;
            wb_rd_q        <= 5'd0;
            wb_reg_write_q <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            bus_err_q      <= bus_err_d;
        end
    end

    // Bus fields are zeroed outside an active request so reset quiets them too.
    assign o_dmem_req     = w_req;
    assign o_dmem_we      = w_req & w_is_store;
    assign o_dmem_addr    = w_req ? {i_alu_result[31:2], 2'b00} : 32'h0;
    assign o_dmem_wdata   = (w_req & w_is_store) ? w_store_data : 32'h0;
    assign o_dmem_mask    = (w_req & w_is_store) ? w_store_mask : 4'h0;

    assign o_stall        = w_memop & ~w_done & ~i_rst;

    assign o_wb_valid     = wb_valid_q;
    assign o_wb_data      = wb_data_q;
    assign o_wb_rd_addr   = wb_rd_q;
    assign o_wb_reg_write = wb_reg_write_q;
    assign o_bus_err      = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage: directed cases plus randomized
//            ops scored against a cycle-count/arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int C_TO = 15;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_alu_result = 32'h0;
    logic [31:0] i_rs2_rdata = 32'h0;
    logic [2:0]  i_funct3 = 3'b0;
    logic [4:0]  i_rd_addr = 5'd0;
    logic [31:0] i_pc_plus_4 = 32'h0;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic        i_reg_write = 1'b0;
    logic        i_mem_to_reg = 1'b0;
    logic        i_jump = 1'b0;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_mask;
    logic        i_dmem_ready = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic        o_stall;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd_addr;
    logic        o_wb_reg_write;
    logic        o_bus_err;
    logic        o_misalign;

    int checks   = 0;
    int failures = 0;

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    mem_stage #(.TIMEOUT(C_TO)) u_dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_alu_result   (i_alu_result),
        .i_rs2_rdata    (i_rs2_rdata),
        .i_funct3       (i_funct3),
        .i_rd_addr      (i_rd_addr),
        .i_pc_plus_4    (i_pc_plus_4),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_reg_write    (i_reg_write),
        .i_mem_to_reg   (i_mem_to_reg),
        .i_jump         (i_jump),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wdata   (o_dmem_wdata),
        .o_dmem_mask    (o_dmem_mask),
        .i_dmem_ready   (i_dmem_ready),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_stall        (o_stall),
        .o_wb_valid     (o_wb_valid),
        .o_wb_data      (o_wb_data),
        .o_wb_rd_addr   (o_wb_rd_addr),
        .o_wb_reg_write (o_wb_reg_write),
        .o_bus_err      (o_bus_err),
        .o_misalign     (o_misalign)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a[1:0])) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b ^ 32'h80) - 32'h80;
            3'b001:  return (h ^ 32'h8000) - 32'h8000;
            3'b100:  return b;
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'b00:   return 4'(1 << a[1:0]);
            2'b01:   return 4'(3 << (a[1:0] & 2'b10));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return (d & 32'hFF) * 32'h0101_0101;
            2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // Presents one instruction at posedge+1 and walks it cycle by cycle.
    // d_r: REQ cycles with ready low; d_v: WAIT cycles before rvalid.
    task automatic run_op(input logic v, input logic mr, input logic mw, input logic rw,
                          input logic jmp, input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [31:0] pc4,
                          input logic [31:0] rdata, input logic [4:0] rda,
                          input int d_r, input int d_v, input bit noise);
        logic memop, ld, st, mis, abort, retire, exp_req;
        logic [31:0] exp_data;
        int t_ret;
        memop = v & (mr | mw);
        ld    = mr;
        st    = ~mr & mw;
        mis   = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        if (memop && f3[1:0] == 2'b01 && alu[0]) mis = 1'b1;
        if (memop && f3[1:0] == 2'b10 && alu[1:0] != 2'b00) mis = 1'b1;
`endif
        abort  = 1'b0;
        retire = v;
        t_ret  = 0;
        if (memop && !mis) begin
            if (st) begin
                if (d_r < C_TO) t_ret = 1 + d_r;
                else begin t_ret = C_TO + 1; abort = 1'b1; end
            end else begin
                if (d_r < C_TO && (1 + d_r + d_v) < C_TO) t_ret = 2 + d_r + d_v;
                else begin t_ret = C_TO + 1; abort = 1'b1; end
            end
        end
        exp_data = jmp ? pc4 : (mr ? m_load(f3, alu, rdata) : alu);

        i_valid = v; i_mem_read = mr; i_mem_write = mw; i_reg_write = rw;
        i_mem_to_reg = mr; i_jump = jmp; i_funct3 = f3; i_alu_result = alu;
        i_rs2_rdata = rs2; i_pc_plus_4 = pc4; i_dmem_rdata = rdata; i_rd_addr = rda;
        for (int t = 0; t <= t_ret; t++) begin
            i_dmem_ready  = (t == 1 + d_r);
            i_dmem_rvalid = (ld && t == 2 + d_r + d_v) ||
                            (noise && (!ld || t <= 1 + d_r) && $urandom_range(0, 1) == 1);
            exp_req = memop && !mis && t >= 1 && t <= 1 + d_r && t <= C_TO;
            @(negedge i_clk);
            chk("stall", 32'(o_stall), 32'(memop && t < t_ret));
            chk("dmem_req", 32'(o_dmem_req), 32'(exp_req));
            if (exp_req) begin
                chk("dmem_addr", o_dmem_addr, alu & 32'hFFFF_FFFC);
                chk("dmem_we", 32'(o_dmem_we), 32'(st));
                if (st) begin
                    chk("dmem_mask", 32'(o_dmem_mask), 32'(m_mask(f3, alu)));
                    chk("dmem_wdata", o_dmem_wdata, m_wdata(f3, rs2));
                end
            end
            @(posedge i_clk);
            #1;
            if (t == t_ret && retire) begin
                chk("wb_valid", 32'(o_wb_valid), 32'd1);
                chk("wb_rd", 32'(o_wb_rd_addr), 32'(rda));
                chk("wb_reg_write", 32'(o_wb_reg_write), 32'(rw && !abort && !mis));
                chk("bus_err", 32'(o_bus_err), 32'(abort));
                chk("misalign", 32'(o_misalign), 32'(mis));
                if (!abort && !mis) chk("wb_data", o_wb_data, exp_data);
            end else begin
                chk("bubble_valid", 32'(o_wb_valid), 32'd0);
                chk("bubble_reg_write", 32'(o_wb_reg_write), 32'd0);
                chk("bubble_bus_err", 32'(o_bus_err), 32'd0);
            end
        end
        i_dmem_ready  = 1'b0;
        i_dmem_rvalid = 1'b0;
    endtask

    int          op, dr, dv;
    logic [31:0] a, d, r, p;
    logic [2:0]  f;

    initial begin
        // Reset state
        #12;
        chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_dmem_req", 32'(o_dmem_req), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        // ADD retire, LB/LBU lane + sign, SH with stalled bus, LW timeout
        run_op(1, 0, 0, 1, 0, 3'b000, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd5, 0, 0, 0);
        run_op(1, 1, 0, 1, 0, 3'b000, 32'h103, 32'h0, 32'h0, 32'h80FF_FF00, 5'd6, 0, 0, 0);
        chk("lb_value", o_wb_data, 32'hFFFF_FF80);
        run_op(1, 1, 0, 1, 0, 3'b100, 32'h103, 32'h0, 32'h0, 32'h80FF_FF00, 5'd7, 0, 0, 0);
        chk("lbu_value", o_wb_data, 32'h0000_0080);
        run_op(1, 0, 1, 0, 0, 3'b001, 32'h102, 32'hABCD, 32'h0, 32'h0, 5'd0, 4, 0, 0);
        run_op(1, 1, 0, 1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 32'h5555_AAAA, 5'd8, 0, 100, 0);
        run_op(1, 0, 0, 1, 1, 3'b000, 32'h77, 32'h0, 32'h4004, 32'h0, 5'd1, 0, 0, 0);
        run_op(0, 1, 0, 1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 32'h0, 5'd9, 0, 0, 0);
        run_op(1, 0, 1, 0, 0, 3'b010, 32'h400, 32'h1, 32'h0, 32'h0, 5'd0, C_TO, 0, 0);
        run_op(1, 1, 0, 1, 0, 3'b010, 32'h404, 32'h0, 32'h0, 32'h1, 5'd2, 0, C_TO - 2, 0);
        run_op(1, 1, 0, 1, 0, 3'b010, 32'h408, 32'h0, 32'h0, 32'h2, 5'd3, 0, C_TO - 3, 1);
`ifdef MEM_MISALIGN_CHECK_EN
        run_op(1, 1, 0, 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 32'h0, 5'd4, 0, 0, 0);
        chk("misalign_pulse", 32'(o_misalign), 32'd1);
`endif

        // Reset asserted mid-WAIT; late response must be ignored
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_reg_write = 1'b1;
        i_jump = 1'b0; i_funct3 = 3'b010; i_alu_result = 32'h500; i_rd_addr = 5'd10;
        @(posedge i_clk);
        #1 i_dmem_ready = 1'b1;
        @(posedge i_clk);
        #1 i_dmem_ready = 1'b0;
        @(negedge i_clk);
        chk("wait_stall", 32'(o_stall), 32'd1);
        #1 i_rst = 1'b1;
        #1;
        chk("async_rst_stall", 32'(o_stall), 32'd0);
        chk("async_rst_req", 32'(o_dmem_req), 32'd0);
        chk("async_rst_wb_data", o_wb_data, 32'd0);
        chk("async_rst_wb_rd", 32'(o_wb_rd_addr), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0; i_valid = 1'b0; i_dmem_rvalid = 1'b1;
        @(posedge i_clk);
        #1 i_dmem_rvalid = 1'b0;
        chk("late_rvalid_wb", 32'(o_wb_valid), 32'd0);
        chk("late_rvalid_req", 32'(o_dmem_req), 32'd0);
        run_op(1, 1, 0, 1, 0, 3'b001, 32'h602, 32'h0, 32'h0, 32'h8001_0000, 5'd11, 0, 0, 0);

        // Randomized ops
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 4);
            a  = $urandom;
            d  = $urandom;
            r  = $urandom;
            p  = $urandom;
            dr = ($urandom_range(0, 9) == 0) ? $urandom_range(C_TO - 2, C_TO + 2) : $urandom_range(0, 3);
            dv = ($urandom_range(0, 9) == 0) ? $urandom_range(C_TO - 4, C_TO) : $urandom_range(0, 3);
            case (op)
                0: run_op(1, 0, 0, $urandom_range(0, 1) == 1, 0, 3'($urandom), a, d, p, r,
                          5'($urandom), 0, 0, 1);
                1: run_op(1, 0, 0, 1, 1, 3'b000, a, d, p, r, 5'($urandom), 0, 0, 1);
                2: begin
                    f = ld_f3[$urandom_range(0, 4)];
                    if (f[1:0] == 2'b01) a[0] = 1'b0;
                    if (f[1:0] == 2'b10) a[1:0] = 2'b00;
                    run_op(1, 1, 0, 1, 0, f, a, d, p, r, 5'($urandom), dr, dv, 1);
                end
                3: begin
                    f = 3'($urandom_range(0, 2));
                    if (f[1:0] == 2'b01) a[0] = 1'b0;
                    if (f[1:0] == 2'b10) a[1:0] = 2'b00;
                    run_op(1, 0, 1, $urandom_range(0, 1) == 1, 0, f, a, d, p, r,
                           5'($urandom), dr, 0, 1);
                end
                default: run_op(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, 0,
                                3'b010, a, d, p, r, 5'($urandom), 0, 0, 1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: bus wait-cycle limit before a transaction is aborted; legal range 1..255.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_valid  in  1  EX/MEM slot holds a live instruction.
REQ-005 i_alu_result  in  32  memory byte address, or ALU result for non-memory ops.
REQ-006 i_rs2_rdata  in  32  store data.
REQ-007 i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 i_rd_addr  in  5  destination register.
REQ-009 i_pc_plus_4  in  32  link value for jumps.
REQ-010 i_mem_read, i_mem_write, i_reg_write, i_mem_to_reg, i_jump  in  1 each  EX/MEM control bits.
REQ-011 o_dmem_req  out  1  bus request valid.
REQ-012 o_dmem_we  out  1  1 = store, 0 = load.
REQ-013 o_dmem_addr  out  32  word-aligned address {i_alu_result[31:2],2'b00}.
REQ-014 o_dmem_wdata  out  32  lane-replicated store data.
REQ-015 o_dmem_mask  out  4  byte-enable mask.
REQ-016 i_dmem_ready  in  1  bus accepts request this cycle.
REQ-017 i_dmem_rvalid, i_dmem_rdata  in  1, 32  load response.
REQ-018 o_stall  out  1  combinational; upstream holds all inputs stable while high.
REQ-019 o_wb_valid, o_wb_data, o_wb_rd_addr, o_wb_reg_write  out  1, 32, 5, 1  registered MEM/WB result.
REQ-020 o_bus_err  out  1  one-cycle pulse on timeout abort.
REQ-021 o_misalign  out  1  one-cycle pulse on misaligned access (see Configuration).

Function
REQ-022 FSM states IDLE, REQ, WAIT; memop = i_valid & (i_mem_read | i_mem_write); i_mem_read has priority over i_mem_write when both are set.
REQ-023 IDLE: on memop, move to REQ next edge; non-memops retire at the next edge (1-cycle latency).
REQ-024 REQ: o_dmem_req=1; on i_dmem_ready, a store retires and returns to IDLE, a load moves to WAIT.
REQ-025 WAIT: on i_dmem_rvalid, the load retires and returns to IDLE; i_dmem_rvalid outside WAIT is ignored.
REQ-026 done = (REQ & ready & store) | (WAIT & rvalid) | timeout; o_stall = memop & ~done.
REQ-027 Minimum latency: store 2 cycles, load 3 cycles, from memop first presented to o_wb_valid.
REQ-028 Wait counter clears on entry to REQ and counts every REQ/WAIT cycle; reaching TIMEOUT forces done, drops o_dmem_req, pulses o_bus_err, and retires with o_wb_reg_write=0.
REQ-029 Store mask: B 4'b0001<<addr[1:0], H 4'b0011<<{addr[1],1'b0} truncated to 4 bits, W 4'b1111.
REQ-030 Store wdata: B byte x4, H half x2, W as-is.
REQ-031 Load: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W as-is.
REQ-032 o_wb_data priority: i_jump -> i_pc_plus_4; i_mem_read -> formatted load; else i_alu_result.
REQ-033 At each retire edge: o_wb_valid=1 and rd/reg_write copied; otherwise o_wb_valid=0 and o_wb_reg_write=0 (bubble).
REQ-034 i_valid=0 produces a bubble and never stalls.

Reset
REQ-035 i_rst forces IDLE, counter 0, and all outputs 0 immediately, independent of clock; an in-flight request is dropped and its late response is ignored.

Configuration
REQ-036 MEM_MISALIGN_CHECK_EN defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, issues no bus request, retires in 1 cycle with o_wb_reg_write=0, and pulses o_misalign.
REQ-037 MEM_MISALIGN_CHECK_EN undefined: o_misalign is tied 0 and accesses proceed using the REQ-029/031 lane rules.

Verification
REQ-038 ADD retire: i_alu_result=0x1234, reg_write=1, rd=5 -> next edge wb_valid=1, wb_data=0x1234, no stall.
REQ-039 LB at 0x103 with rdata=0x80FF_FF00 -> mask n/a, wb_data=0xFFFF_FF80; LBU gives 0x0000_0080; latency 3 with ready and rvalid both immediate.
REQ-040 SH at 0x102 with rs2=0xABCD -> addr=0x100, mask=4'b1100, wdata=0xABCD_ABCD; ready held low 4 cycles -> stall held 5 cycles.
REQ-041 LW where rvalid is never returned, TIMEOUT=15 -> abort after 15 wait cycles, o_bus_err pulse, wb_reg_write=0.
REQ-042 Assert i_rst while in WAIT, then rvalid arrives -> outputs 0 at once, state IDLE, response ignored; with MEM_MISALIGN_CHECK_EN, LW at 0x102 -> o_misalign=1, o_dmem_req stays 0.
